alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 req_valid  input  2  per-requester request valid; index 0 = requester 0, index 1 = requester 1.
REQ-005 req_ready  output  2  per-requester accept; a request is accepted on a cycle with req_valid[i] & req_ready[i].
REQ-006 req_a, req_b  input  2x16 each  per-requester operands.
REQ-007 req_op  input  2x4  per-requester ALU opcode, 4'b0000..4'b1011 legal.
REQ-008 alu_a, alu_b  output  16 each  registered operands to the shared ALU.
REQ-009 alu_control  output  4  registered opcode to the shared ALU.
REQ-010 alu_result  input  17  ALU result; alu_zero, alu_carry, alu_parity  input  1 each  ALU flags.
REQ-011 rsp_valid  output  1  response valid; rsp_ready  input  1  response accept.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_result  output  17; rsp_zero, rsp_carry, rsp_parity, rsp_err  output  1 each  captured result and flags.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-015 In IDLE, req_ready SHALL be one-hot on the granted requester, or all zero if neither is valid; in EXEC and RESP, req_ready SHALL be 2'b00.
REQ-016 Grant SHALL be round-robin: if one requester is valid it wins; if both are valid, the requester not served last wins; after reset, requester 0 has priority.
REQ-017 On acceptance, the block SHALL register the operands and opcode onto alu_a/alu_b/alu_control and SHALL move to EXEC.
REQ-018 In EXEC, the block SHALL capture alu_result and the three flags into the rsp_* registers and SHALL move to RESP; rsp_valid SHALL rise on the cycle after EXEC, two cycles after acceptance.
REQ-019 In RESP, rsp_valid SHALL stay high, with all rsp_* stable, until rsp_valid & rsp_ready; the block SHALL then return to IDLE, with the next grant one cycle later (no accept in the same cycle as the response handshake).
REQ-020 An illegal opcode (4'b1100..4'b1111) SHALL be accepted and SHALL go straight from IDLE to RESP with rsp_result=0, rsp_zero=1, rsp_carry=0, rsp_parity=0 and rsp_err=1; alu_control SHALL not change.
REQ-021 rsp_err SHALL be 0 for every legal-opcode response unless REQ-026 applies.
REQ-022 A deasserted req_valid while not granted SHALL have no effect; a requester's operands need to be stable only in its accept cycle.
REQ-023 Throughput SHALL be at most one operation per 3 cycles (4 with back-pressure).

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL enter IDLE, set the round-robin pointer to requester 0, and clear alu_a, alu_b, alu_control, rsp_result and every rsp_* flag to 0, so req_ready=2'b00 and rsp_valid=0.
REQ-025 A reset during EXEC or RESP SHALL discard the in-flight operation without producing a response.

Configuration
REQ-026 With ALU_DIV_GUARD_EN defined, a divide (4'b0000) with b=0 SHALL go IDLE->RESP with rsp_result=17'h1FFFF, rsp_zero=0, rsp_carry=1, rsp_parity=1 and rsp_err=1, and SHALL not drive the ALU; without the macro, the divide SHALL be issued to the ALU normally.

Structure
REQ-027 A shared package alu_pkg SHALL hold the 4-bit opcode constants (DIV, ADD, SUB, MUL, AND, OR, XOR, NOT, SHR1, SHL, INC, DEC), the last-legal-opcode constant and the FSM state enum.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], advance; output one-hot grant[1:0]); the ALU SHALL stay external.

Verification
REQ-029 Single ADD: requester 0 sends a=16'h0003, b=16'h0004, op=0001 -> rsp_valid two cycles later with rsp_id=0, rsp_result=17'h00007, zero=0, err=0.
REQ-030 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id alternates the same way.
REQ-031 Back-pressure: SUB with a=5, b=5 and rsp_ready held low for 4 cycles -> rsp_valid held high with result 0 and zero=1 stable, req_ready=00 throughout.
REQ-032 Illegal op: op=4'b1110 -> response one cycle after accept with rsp_err=1 and result 0, and alu_control unchanged.
REQ-033 Divide by zero: op=0000, b=0 -> with ALU_DIV_GUARD_EN, result 17'h1FFFF and err=1; without it, the value returned by the ALU and err=0.
REQ-034 Reset in EXEC: rst_n low for 1 cycle -> no response, all outputs 0, and a simultaneous two-requester request is then granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the ALU arbiter slice.
package alu_pkg;

   localparam logic [3:0] OpDiv  = 4'h0;
   localparam logic [3:0] OpAdd  = 4'h1;
   localparam logic [3:0] OpSub  = 4'h2;
   localparam logic [3:0] OpMul  = 4'h3;
   localparam logic [3:0] OpAnd  = 4'h4;
   localparam logic [3:0] OpOr   = 4'h5;
   localparam logic [3:0] OpXor  = 4'h6;
   localparam logic [3:0] OpNot  = 4'h7;
   localparam logic [3:0] OpShr1 = 4'h8;
   localparam logic [3:0] OpShl  = 4'h9;
   localparam logic [3:0] OpInc  = 4'hA;
   localparam logic [3:0] OpDec  = 4'hB;

   localparam logic [3:0] LastLegalOp = OpDec;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= LastLegalOp;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the ALU arbiter.
interface alu_arbiter_if;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][15:0] req_a;
   logic [1:0][15:0] req_b;
   logic [1:0][3:0]  req_op;

   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_control;
   logic [16:0] alu_result;
   logic        alu_zero;
   logic        alu_carry;
   logic        alu_parity;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [16:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_carry;
   logic        rsp_parity;
   logic        rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_zero, alu_carry, alu_parity,
      input  req_ready, alu_a, alu_b, alu_control,
             rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_parity, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_zero, alu_carry, alu_parity,
      output req_ready, alu_a, alu_b, alu_control,
             rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_parity, rsp_err
   );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic prio_q, prio_d;  // set: requester 1 wins a tie

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      prio_d = prio_q;
      if (advance) prio_d = grant[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU. With ALU_DIV_GUARD_EN defined,
// divide-by-zero is answered locally without issuing to the ALU.
module alu_arbiter
   import alu_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus_io
);

   state_e      state_q, state_d;
   logic [1:0]  grant;
   logic [1:0]  req_ready;
   logic        accept;
   logic        sel;
   logic [15:0] op_a, op_b;
   logic [3:0]  op_code;

   logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]  alu_ctrl_q, alu_ctrl_d;
   logic [16:0] rsp_result_q, rsp_result_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_zero_q, rsp_zero_d, rsp_carry_q, rsp_carry_d;
   logic        rsp_parity_q, rsp_parity_d, rsp_err_q, rsp_err_d;

   rr_arbiter_2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus_io.req_valid),
      .advance (accept),
      .grant   (grant)
   );

   assign req_ready = (state_q == StIdle) ? grant : 2'b00;
   assign accept    = |(bus_io.req_valid & req_ready);
   assign sel       = grant[1];
   assign op_a      = bus_io.req_a[sel];
   assign op_b      = bus_io.req_b[sel];
   assign op_code   = bus_io.req_op[sel];

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_parity_d = rsp_parity_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               rsp_id_d = sel;
               // Locally answered requests skip EXEC and leave the ALU inputs untouched.
               if (!op_legal(op_code)) begin
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b1;
                  rsp_carry_d  = 1'b0;
                  rsp_parity_d = 1'b0;
                  rsp_err_d    = 1'b1;
                  state_d      = StResp;
               end
`ifdef ALU_DIV_GUARD_EN
               else if (op_code == OpDiv && op_b == '0) begin
                  rsp_result_d = 17'h1FFFF;
                  rsp_zero_d   = 1'b0;
                  rsp_carry_d  = 1'b1;
                  rsp_parity_d = 1'b1;
                  rsp_err_d    = 1'b1;
                  state_d      = StResp;
               end
`endif
               else begin
                  alu_a_d    = op_a;
                  alu_b_d    = op_b;
                  alu_ctrl_d = op_code;
                  state_d    = StExec;
               end
            end
         end
         StExec: begin
            rsp_result_d = bus_io.alu_result;
            rsp_zero_d   = bus_io.alu_zero;
            rsp_carry_d  = bus_io.alu_carry;
            rsp_parity_d = bus_io.alu_parity;
            rsp_err_d    = 1'b0;
            state_d      = StResp;
         end
         StResp: begin
            if (bus_io.rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_result_q <= '0;
         rsp_id_q     <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_carry_q  <= 1'b0;
         rsp_parity_q <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_parity_q <= rsp_parity_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus_io.req_ready   = req_ready;
   assign bus_io.alu_a       = alu_a_q;
   assign bus_io.alu_b       = alu_b_q;
   assign bus_io.alu_control = alu_ctrl_q;
   assign bus_io.rsp_valid   = (state_q == StResp);
   assign bus_io.rsp_id      = rsp_id_q;
   assign bus_io.rsp_result  = rsp_result_q;
   assign bus_io.rsp_zero    = rsp_zero_q;
   assign bus_io.rsp_carry   = rsp_carry_q;
   assign bus_io.rsp_parity  = rsp_parity_q;
   assign bus_io.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU; honours ALU_DIV_GUARD_EN.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference ALU: DIV (x/0 -> 0FFFF), ADD, SUB, otherwise AND.
   logic [16:0] alu_res;
   always_comb begin
      case (bus.alu_control)
         4'h0:    alu_res = (bus.alu_b == 16'h0) ? 17'h0FFFF : {1'b0, bus.alu_a / bus.alu_b};
         4'h1:    alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         4'h2:    alu_res = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         default: alu_res = {1'b0, bus.alu_a & bus.alu_b};
      endcase
   end
   assign bus.alu_result = alu_res;
   assign bus.alu_zero   = (alu_res == 17'h0);
   assign bus.alu_carry  = alu_res[16];
   assign bus.alu_parity = ^alu_res[15:0];

   logic [3:0] rsp_flags;  // {zero, carry, parity, err}
   assign rsp_flags = {bus.rsp_zero, bus.rsp_carry, bus.rsp_parity, bus.rsp_err};

   task automatic set_req(input logic idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op);
      bus.req_a[idx]  = a;
      bus.req_b[idx]  = b;
      bus.req_op[idx] = op;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_hs: got %b want 000", {bus.req_ready, bus.rsp_valid});
      end
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_control} !== 36'h0) begin
         errors++;
         $display("FAIL reset_alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_control});
      end
      checks++;
      if ({bus.rsp_result, rsp_flags, bus.rsp_id} !== 22'h0) begin
         errors++;
         $display("FAIL reset_rsp: got %h want 0", {bus.rsp_result, rsp_flags, bus.rsp_id});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_add();
      set_req(1'b0, 16'h0003, 16'h0004, 4'h1);
      bus.req_valid = 2'b01;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL add_grant: got %b want 01", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_control} !==
          {2'b00, 1'b0, 16'h0003, 16'h0004, 4'h1}) begin
         errors++;
         $display("FAIL add_exec: got %h want 0000300041",
                  {bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_control});
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags} !==
          {1'b1, 1'b0, 17'h00007, 4'b0010}) begin
         errors++;
         $display("FAIL add_rsp: got v%b id%b r%h f%b want v1 id0 r00007 f0010",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_done: rsp_valid got %b want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_contention();
      logic        exp_id;
      logic [16:0] exp_res;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_req(1'b0, 16'd1, 16'd1, 4'h1);
      set_req(1'b1, 16'd10, 16'd20, 4'h1);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_id  = i[0];
         exp_res = exp_id ? 17'd30 : 17'd2;
         #1;
         checks++;
         if (bus.req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rr_grant%0d: got %b want id %b", i, bus.req_ready, exp_id);
         end
         repeat (2) @(negedge clk);
         #1;
         checks++;
         if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, exp_id, exp_res}) begin
            errors++;
            $display("FAIL rr_rsp%0d: got v%b id%b r%h want v1 id%b r%h", i, bus.rsp_valid,
                     bus.rsp_id, bus.rsp_result, exp_id, exp_res);
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      set_req(1'b1, 16'd5, 16'd5, 4'h2);
      bus.req_valid = 2'b10;
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL bp_grant: got %b want 10", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b11;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({bus.rsp_valid, bus.rsp_result, rsp_flags, bus.req_ready} !==
             {1'b1, 17'h0, 4'b1000, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v%b r%h f%b rdy%b want v1 r0 f1000 rdy00", i,
                     bus.rsp_valid, bus.rsp_result, rsp_flags, bus.req_ready);
         end
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin
         errors++;
         $display("FAIL bp_hs_ready: got %b want 00", bus.req_ready);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL bp_release: got %b want 001", {bus.rsp_valid, bus.req_ready});
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_illegal_op();
      set_req(1'b0, 16'h1234, 16'h5678, 4'hE);
      bus.req_valid = 2'b01;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL ill_grant: got %b want 01", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags} !==
          {1'b1, 1'b0, 17'h0, 4'b1001}) begin
         errors++;
         $display("FAIL ill_rsp: got v%b id%b r%h f%b want v1 id0 r0 f1001",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags);
      end
      checks++;
      if ({bus.alu_control, bus.alu_a} !== {4'h2, 16'd5}) begin
         errors++;
         $display("FAIL ill_alu: got %h want 20005", {bus.alu_control, bus.alu_a});
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_div_zero();
      set_req(1'b1, 16'd100, 16'd0, 4'h0);
      bus.req_valid = 2'b10;
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL div_grant: got %b want 10", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
`ifdef ALU_DIV_GUARD_EN
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags, bus.alu_control} !==
          {1'b1, 1'b1, 17'h1FFFF, 4'b0111, 4'h2}) begin
         errors++;
         $display("FAIL div_guard: got v%b id%b r%h f%b ctl%h want v1 id1 r1ffff f0111 ctl2",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags, bus.alu_control);
      end
`else
      checks++;
      if ({bus.rsp_valid, bus.alu_control, bus.alu_b} !== {1'b0, 4'h0, 16'h0}) begin
         errors++;
         $display("FAIL div_issue: got v%b ctl%h b%h want v0 ctl0 b0",
                  bus.rsp_valid, bus.alu_control, bus.alu_b);
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags} !==
          {1'b1, 1'b1, 17'h0FFFF, 4'b0000}) begin
         errors++;
         $display("FAIL div_rsp: got v%b id%b r%h f%b want v1 id1 r0ffff f0000",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_result, rsp_flags);
      end
`endif
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_in_exec();
      set_req(1'b0, 16'd7, 16'd8, 4'h1);
      set_req(1'b1, 16'd1, 16'd2, 4'h1);
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_pre_grant: got %b want 01", bus.req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.alu_a, bus.req_ready} !== {16'd7, 2'b00}) begin
         errors++;
         $display("FAIL rst_exec: got %h want 001c", {bus.alu_a, bus.req_ready});
      end
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_control} !== 39'h0) begin
         errors++;
         $display("FAIL rst_clear_alu: got %h want 0",
                  {bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_control});
      end
      checks++;
      if ({bus.rsp_result, rsp_flags, bus.rsp_id} !== 22'h0) begin
         errors++;
         $display("FAIL rst_clear_rsp: got %h want 0", {bus.rsp_result, rsp_flags, bus.rsp_id});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp%0d: rsp_valid got %b want 0", i, bus.rsp_valid);
         end
      end
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_post_grant: got %b want 01", bus.req_ready);
      end
      bus.req_valid = 2'b00;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single_add();
      test_contention();
      test_back_pressure();
      test_illegal_op();
      test_div_zero();
      test_reset_in_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
